// File: rtl/sos_stream_ctrl.sv
// Sample-rate sequencer for the SOS cascade. One sample is accepted on the
// input handshake and driven onto x_o. The controller then waits for the
// combinational biquad chain to settle, captures y_i, and pulses state_en_o
// so that every z^-1 register updates on that same edge. The filtered sample
// is then offered on the output valid/ready port.
module sos_stream_ctrl #(
   parameter int WD         = 16,
   parameter int SETTLE_CYC = 4,
   parameter int CW         = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          s_valid_i,
   output logic          s_ready_o,
   input  logic [WD-1:0] s_data_i,
   output logic [WD-1:0] x_o,
   input  logic [WD-1:0] y_i,
   output logic          state_en_o,
   output logic          m_valid_o,
   input  logic          m_ready_i,
   output logic [WD-1:0] m_data_o,
   output logic          busy_o,
   output logic [CW-1:0] sample_cnt_o
);

   // Settle counter width; kept at least 1 bit so SETTLE_CYC=1 still builds.
   localparam int CNTW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2,
      OUT     = 2'd3
   } state_t;

   state_t          state_reg, state_next;
   logic [CNTW-1:0] cnt_reg, cnt_next;
   logic [WD-1:0]   x_reg, x_next;
   logic [WD-1:0]   m_data_reg, m_data_next;
   logic            m_valid_reg, m_valid_next;
   logic [CW-1:0]   sample_cnt_reg, sample_cnt_next;

   // State and datapath registers; reset aborts any sample in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         x_reg          <= '0;
         m_data_reg     <= '0;
         m_valid_reg    <= 1'b0;
         sample_cnt_reg <= '0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         x_reg          <= x_next;
         m_data_reg     <= m_data_next;
         m_valid_reg    <= m_valid_next;
         sample_cnt_reg <= sample_cnt_next;
      end
   end

   // Next-state and next-data logic; every register holds by default.
   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      x_next          = x_reg;
      m_data_next     = m_data_reg;
      m_valid_next    = m_valid_reg;
      sample_cnt_next = sample_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (s_valid_i) begin
               x_next     = s_data_i;
               cnt_next   = CNTW'(SETTLE_CYC - 1);
               state_next = SETTLE;
            end
         end
         SETTLE: begin
            // Counts SETTLE_CYC-1 down to 0, so this state spans SETTLE_CYC cycles.
            if (cnt_reg == '0) begin
               state_next = CAPTURE;
            end else begin
               cnt_next = cnt_reg - CNTW'(1);
            end
         end
         CAPTURE: begin
            // y_i still reflects the old delay state; the delays latch on this edge.
            m_data_next  = y_i;
            m_valid_next = 1'b1;
            state_next   = OUT;
         end
         OUT: begin
            if (m_ready_i) begin
               m_valid_next    = 1'b0;
               sample_cnt_next = sample_cnt_reg + CW'(1);
               state_next      = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs are decoded from registered state; the enable is masked during reset.
   always_comb begin
      s_ready_o    = (state_reg == IDLE);
      state_en_o   = (state_reg == CAPTURE) && !rst_i;
      busy_o       = (state_reg != IDLE);
      x_o          = x_reg;
      m_data_o     = m_data_reg;
      m_valid_o    = m_valid_reg;
      sample_cnt_o = sample_cnt_reg;
   end

endmodule
